// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_HI = 3'd1,
    ST_LEN_LO = 3'd2,
    ST_DATA   = 3'd3,
    ST_CHECK  = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERROR  = 3'd6
  } state_e;

  localparam int unsigned HDR_BYTES = 2;
  localparam int unsigned CHK_BYTES = 1;
  localparam int unsigned LEN_W     = 8 * HDR_BYTES;
  localparam int unsigned CHK_W     = 8 * CHK_BYTES;

  // States in which the loader consumes stream bytes.
  function automatic logic rx_state(input state_e s);
    return (s == ST_LEN_HI) || (s == ST_LEN_LO) || (s == ST_DATA) || (s == ST_CHECK);
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input, RAM write port and core-control outputs of the loader.
interface imem_loader_if #(
  parameter int unsigned AW = 6
) ();
  logic          start;
  logic          byte_valid;
  logic [7:0]    byte_data;
  logic          byte_ready;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          hold;
  logic          done;
  logic          error;

  modport master (
    output start, byte_valid, byte_data,
    input  byte_ready, mem_we, mem_addr, mem_wdata, hold, done, error
  );

  modport slave (
    input  start, byte_valid, byte_data,
    output byte_ready, mem_we, mem_addr, mem_wdata, hold, done, error
  );
endinterface

// File: rtl/imem_loader_byte_packer.sv
// Packs bytes MSB-first into 32-bit words; registered one-cycle word pulse.
module imem_loader_byte_packer (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear_i,
  input  logic        byte_en_i,
  input  logic [7:0]  byte_i,
  output logic [1:0]  byte_cnt_o,
  output logic        word_valid_o,
  output logic [31:0] word_o
);

  logic [1:0]  cnt_q, cnt_d;
  logic [23:0] shift_q, shift_d;
  logic        valid_q, valid_d;
  logic [31:0] word_q, word_d;

  // Next-state: shift in accepted bytes, emit the word on the fourth.
  always_comb begin
    cnt_d   = cnt_q;
    shift_d = shift_q;
    valid_d = 1'b0;
    word_d  = word_q;
    if (clear_i) begin
      cnt_d   = '0;
      shift_d = '0;
    end else if (byte_en_i) begin
      cnt_d   = 2'(cnt_q + 2'd1);
      shift_d = {shift_q[15:0], byte_i};
      if (cnt_q == 2'd3) begin
        valid_d = 1'b1;
        word_d  = {shift_q, byte_i};
      end
    end
  end

  // State registers; reset drops any pending word pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      shift_q <= '0;
      valid_q <= 1'b0;
      word_q  <= '0;
    end else begin
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      valid_q <= valid_d;
      word_q  <= word_d;
    end
  end

  assign byte_cnt_o   = cnt_q;
  assign word_valid_o = valid_q;
  assign word_o       = word_q;

endmodule

// File: rtl/imem_loader.sv
// Loads a length-prefixed, XOR-checked byte stream into instruction RAM.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned AW     = 6,
  parameter int unsigned MAXLEN = 64
) (
  input logic          clk,
  input logic          reset,
  imem_loader_if.slave bus
);

  state_e             state_q, state_d;
  logic [7:0]         len_hi_q, len_hi_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   words_q, words_d;
  logic [CHK_W-1:0]   chk_q, chk_d;
  logic [AW-1:0]      addr_q, addr_d;
  logic               ready_q, ready_d;
  logic               hold_q, hold_d;
  logic               done_q, done_d;
  logic               error_q, error_d;
  logic               accept_c;
  logic               clear_c;
  logic               pk_en_c;
  logic [1:0]         pk_cnt;
  logic               pk_valid;
  logic [31:0]        pk_word;

  assign accept_c = bus.byte_valid && ready_q;
  assign pk_en_c  = accept_c && (state_q == ST_DATA);

  imem_loader_byte_packer u_packer (
    .clk         (clk),
    .reset       (reset),
    .clear_i     (clear_c),
    .byte_en_i   (pk_en_c),
    .byte_i      (bus.byte_data),
    .byte_cnt_o  (pk_cnt),
    .word_valid_o(pk_valid),
    .word_o      (pk_word)
  );

  // Next-state, counters, checksum and status flags.
  always_comb begin
    state_d  = state_q;
    len_hi_d = len_hi_q;
    len_d    = len_q;
    words_d  = words_q;
    chk_d    = chk_q;
    addr_d   = addr_q;
    hold_d   = hold_q;
    done_d   = done_q;
    error_d  = error_q;
    clear_c  = 1'b0;

    if (pk_valid) begin
      addr_d = AW'(addr_q + 1'b1);
    end

    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (bus.start) begin
          state_d = ST_LEN_HI;
          done_d  = 1'b0;
          error_d = 1'b0;
          words_d = '0;
          chk_d   = '0;
          addr_d  = '0;
          hold_d  = 1'b1;
          clear_c = 1'b1;
        end
      end
      ST_LEN_HI: begin
        if (accept_c) begin
          len_hi_d = bus.byte_data;
          chk_d    = chk_q ^ bus.byte_data;
          state_d  = ST_LEN_LO;
        end
      end
      ST_LEN_LO: begin
        if (accept_c) begin
          len_d = {len_hi_q, bus.byte_data};
          chk_d = chk_q ^ bus.byte_data;
          if (len_d > LEN_W'(MAXLEN)) begin
            state_d = ST_ERROR;
            error_d = 1'b1;
          end else if (len_d == '0) begin
            state_d = ST_CHECK;
          end else begin
            state_d = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (accept_c) begin
          chk_d = chk_q ^ bus.byte_data;
          if (pk_cnt == 2'd3) begin
            words_d = LEN_W'(words_q + 1'b1);
            if (words_d == len_q) begin
              state_d = ST_CHECK;
            end
          end
        end
      end
      ST_CHECK: begin
        if (accept_c) begin
          if (bus.byte_data == chk_q) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            hold_d  = 1'b0;
          end else begin
            state_d = ST_ERROR;
            error_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    ready_d = rx_state(state_d);
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath and registered output flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      len_hi_q <= '0;
      len_q    <= '0;
      words_q  <= '0;
      chk_q    <= '0;
      addr_q   <= '0;
      ready_q  <= 1'b0;
      hold_q   <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      len_hi_q <= len_hi_d;
      len_q    <= len_d;
      words_q  <= words_d;
      chk_q    <= chk_d;
      addr_q   <= addr_d;
      ready_q  <= ready_d;
      hold_q   <= hold_d;
      done_q   <= done_d;
      error_q  <= error_d;
    end
  end

  assign bus.byte_ready = ready_q;
  assign bus.mem_we     = pk_valid;
  assign bus.mem_addr   = addr_q;
  assign bus.mem_wdata  = pk_word;
  assign bus.hold       = hold_q;
  assign bus.done       = done_q;
  assign bus.error      = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: stream-level model checked every cycle plus literal end-of-load checks.
module tb_imem_loader;

  localparam int unsigned AW     = 6;
  localparam int          MAXLEN = 64;

  logic clk;
  logic reset;

  imem_loader_if #(.AW(AW)) bus ();

  imem_loader #(.AW(AW), .MAXLEN(MAXLEN)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model of the outputs expected after the next rising edge.
  logic          e_ready, e_we, e_hold, e_done, e_error;
  logic [AW-1:0] e_addr;
  logic [31:0]   e_wdata;
  bit            m_loading;
  int            m_pos, m_len;
  logic [7:0]    m_hi, m_xor;
  logic [31:0]   m_word;

  logic [31:0]   tb_mem [64];
  int            we_count;
  logic [7:0]    s [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    e_ready = 0; e_we = 0; e_hold = 0; e_done = 0; e_error = 0;
    e_addr = '0; e_wdata = '0;
    m_loading = 0; m_pos = 0; m_len = 0; m_hi = '0; m_xor = '0; m_word = '0;
  endtask

  // Advance the stream-level model by one clock given the inputs presented to it.
  task automatic model_step(input logic st, input logic bv, input logic [7:0] bd);
    logic nxt_we;
    nxt_we = 1'b0;
    if (e_we) e_addr = AW'(e_addr + 1);
    if (!m_loading) begin
      if (st) begin
        m_loading = 1; m_pos = 0; m_xor = '0;
        e_done = 0; e_error = 0; e_hold = 1; e_addr = '0; e_ready = 1;
      end
    end else if (bv) begin
      if (m_pos == 0) begin
        m_hi = bd; m_xor = m_xor ^ bd;
      end else if (m_pos == 1) begin
        m_len = int'({m_hi, bd}); m_xor = m_xor ^ bd;
        if (m_len > MAXLEN) begin
          e_error = 1; e_ready = 0; m_loading = 0;
        end
      end else if (m_pos < 2 + 4 * m_len) begin
        m_word = {m_word[23:0], bd}; m_xor = m_xor ^ bd;
        if ((m_pos - 2) % 4 == 3) begin
          nxt_we = 1'b1; e_wdata = m_word;
        end
      end else begin
        if (bd == m_xor) begin e_done = 1; e_hold = 0; end
        else e_error = 1;
        e_ready = 0; m_loading = 0;
      end
      m_pos++;
    end
    e_we = nxt_we;
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (reset) model_reset();
    chk("byte_ready", 32'(bus.byte_ready), 32'(e_ready));
    chk("mem_we",     32'(bus.mem_we),     32'(e_we));
    chk("mem_addr",   32'(bus.mem_addr),   32'(e_addr));
    chk("mem_wdata",  bus.mem_wdata,       e_wdata);
    chk("hold",       32'(bus.hold),       32'(e_hold));
    chk("done",       32'(bus.done),       32'(e_done));
    chk("error",      32'(bus.error),      32'(e_error));
    if (bus.mem_we === 1'b1) begin
      tb_mem[bus.mem_addr] = bus.mem_wdata;
      we_count++;
    end
    if (!reset) model_step(bus.start, bus.byte_valid, bus.byte_data);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 64; i++) tb_mem[i] = 32'hDEAD_BEEF;
    we_count = 0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit taken;
    int waited;
    bus.byte_valid = 1'b0;
    for (int i = 0; i < gap; i++) begin
      bus.byte_data = 8'($urandom);
      tick();
    end
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    taken  = 0;
    waited = 0;
    while (!taken && waited < 40) begin
      @(negedge clk);
      taken = bus.byte_ready;
      tick();
      waited++;
    end
    bus.byte_valid = 1'b0;
    if (!taken) begin
      checks++; errors++;
      $display("FAIL send_byte: byte_ready stayed 0 for 40 cycles, expected 1");
    end
  endtask

  task automatic send_stream(input logic [7:0] q [$], input int max_gap);
    foreach (q[i]) send_byte(q[i], (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0);
  endtask

  task automatic finish_load(input string tag, input logic dn, input logic er, input logic hd, input int nwe);
    repeat (3) tick();
    chk({tag, " done"},     32'(bus.done),       32'(dn));
    chk({tag, " error"},    32'(bus.error),      32'(er));
    chk({tag, " hold"},     32'(bus.hold),       32'(hd));
    chk({tag, " ready"},    32'(bus.byte_ready), 32'd0);
    chk({tag, " we_count"}, 32'(we_count),       32'(nwe));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    bus.start = 1'b0; bus.byte_valid = 1'b0; bus.byte_data = 8'h00;
    clear_mem();
    repeat (3) tick();
    chk("reset hold",  32'(bus.hold),   32'd0);
    chk("reset we",    32'(bus.mem_we), 32'd0);
    reset = 1'b0;
    tick();

    // Two words; XOR of all preceding bytes is 0x8B.
    clear_mem();
    do_start();
    s = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'hAC, 8'h09, 8'h00, 8'h01, 8'h8B};
    send_stream(s, 0);
    finish_load("t1", 1'b1, 1'b0, 1'b0, 2);
    chk("t1 mem0", tb_mem[0], 32'h2008_0005);
    chk("t1 mem1", tb_mem[1], 32'hAC09_0001);

    // Empty program.
    clear_mem();
    do_start();
    s = '{8'h00, 8'h00, 8'h00};
    send_stream(s, 0);
    finish_load("t2", 1'b1, 1'b0, 1'b0, 0);

    // Bad checksum after both words.
    clear_mem();
    do_start();
    s = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'hAC, 8'h09, 8'h00, 8'h01, 8'h00};
    send_stream(s, 0);
    finish_load("t3", 1'b0, 1'b1, 1'b1, 2);
    chk("t3 mem1", tb_mem[1], 32'hAC09_0001);

    // Oversize length, then stray valid bytes that must be ignored.
    clear_mem();
    do_start();
    s = '{8'h00, 8'h41};
    send_stream(s, 0);
    bus.byte_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.byte_data = 8'($urandom);
      tick();
    end
    bus.byte_valid = 1'b0;
    finish_load("t4", 1'b0, 1'b1, 1'b1, 0);

    // Three words with random valid gaps; XOR = 0xCF.
    clear_mem();
    do_start();
    s = '{8'h00, 8'h03, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88,
          8'h99, 8'hAA, 8'hBB, 8'hCC, 8'hCF};
    send_stream(s, 3);
    finish_load("t5", 1'b1, 1'b0, 1'b0, 3);
    chk("t5 mem0", tb_mem[0], 32'h1122_3344);
    chk("t5 mem1", tb_mem[1], 32'h5566_7788);
    chk("t5 mem2", tb_mem[2], 32'h99AA_BBCC);

    // Reset after six data bytes, then a clean reload.
    clear_mem();
    do_start();
    s = '{8'h00, 8'h03, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    send_stream(s, 0);
    reset = 1'b1;
    #1;
    chk("t6 rst ready", 32'(bus.byte_ready), 32'd0);
    chk("t6 rst hold",  32'(bus.hold),       32'd0);
    chk("t6 rst wdata", bus.mem_wdata,       32'd0);
    tick();
    reset = 1'b0;
    repeat (3) tick();
    chk("t6 we_count", 32'(we_count), 32'd1);
    chk("t6 mem0",     tb_mem[0],     32'h0102_0304);
    clear_mem();
    do_start();
    s = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'hAC, 8'h09, 8'h00, 8'h01, 8'h8B};
    send_stream(s, 1);
    finish_load("t6b", 1'b1, 1'b0, 1'b0, 2);
    chk("t6b mem0", tb_mem[0], 32'h2008_0005);
    chk("t6b mem1", tb_mem[1], 32'hAC09_0001);

    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
